// File: rtl/median_pkg.sv
// Shared types and constants for the binary 3x3 median-filter frame controller.
package median_pkg;

    localparam int COORD_W     = 8;
    localparam int ADDR_W      = 2 * COORD_W;
    localparam int WINDOW_SIZE = 3;

    // Frame sequencing phases; source RAM ownership follows the phase.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        FILTER,
        FLUSH,
        DONE
    } state_t;

    // RAM addresses are row-major with the row in the upper byte.
    function automatic logic [ADDR_W-1:0] pack_addr(
        input logic [COORD_W-1:0] y,
        input logic [COORD_W-1:0] x
    );
        return {y, x};
    endfunction

endpackage

// File: rtl/median_res_addr_gen.sv
// Raster-order coordinate generator for the result RAM, with a flag that
// goes high once every position of the OUT_W x OUT_H region has been used.
module median_res_addr_gen
    import median_pkg::*;
#(
    parameter int OUT_W = 126,
    parameter int OUT_H = 126
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_advance,
    output logic [COORD_W-1:0] o_res_x,
    output logic [COORD_W-1:0] o_res_y,
    output logic               o_full
);

    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(OUT_W - 1);
    localparam logic [COORD_W-1:0] END_Y  = COORD_W'(OUT_H);

    logic [COORD_W-1:0] r_res_x;
    logic [COORD_W-1:0] r_res_y;

    // Step one position per accepted result, wrapping x at the end of each row.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            r_res_x <= '0;
            r_res_y <= '0;
        end else if (i_clear) begin
            r_res_x <= '0;
            r_res_y <= '0;
        end else if (i_advance) begin
            if (r_res_x == LAST_X) begin
                r_res_x <= '0;
                r_res_y <= r_res_y + 1'b1;
            end else begin
                r_res_x <= r_res_x + 1'b1;
            end
        end
    end

    assign o_res_x = r_res_x;
    assign o_res_y = r_res_y;
    // Row index reaching OUT_H means the last row has wrapped: region full.
    assign o_full  = (r_res_y == END_Y);

endmodule

// File: rtl/median_frame_ctrl.sv
// Frame sequencer and source-RAM arbiter for the 3x3 median-filter engine.
// The host owns the source RAM during LOAD, the engine during FILTER/FLUSH;
// engine medians are written to the result RAM in raster order.
module median_frame_ctrl
    import median_pkg::*;
#(
    parameter int IMG_W     = 128,
    parameter int IMG_H     = 128,
    parameter int FLUSH_CYC = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               hostReady,
    input  logic               hostWrEn,
    input  logic [COORD_W-1:0] hostX,
    input  logic [COORD_W-1:0] hostY,
    input  logic               hostData,
    input  logic               hostLoadDone,
    output logic               engStart,
    input  logic [COORD_W-1:0] engX,
    input  logic [COORD_W-1:0] engY,
    output logic               engDataIn,
    input  logic               engFullImageDone,
    input  logic               engMedianValid,
    input  logic               engMedianData,
    output logic [ADDR_W-1:0]  memAddr,
    output logic               memWrEn,
    output logic               memWrData,
    input  logic               memRdData,
    output logic [ADDR_W-1:0]  resAddr,
    output logic               resWrEn,
    output logic               resWrData,
    output logic               busy,
    output logic               frameDone,
    output logic [7:0]         frameCount,
    output logic               hostOverrun,
    output logic               resCountErr
);

    localparam int OUT_W   = IMG_W - (WINDOW_SIZE - 1);
    localparam int OUT_H   = IMG_H - (WINDOW_SIZE - 1);
    localparam int FLUSH_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYC - 1);

    state_t             r_state;
    logic [FLUSH_W-1:0] r_flush_cnt;
    logic               r_host_ready;
    logic               r_eng_start;
    logic               r_busy;
    logic               r_frame_done;
    logic [7:0]         r_frame_count;
    logic               r_host_overrun;
    logic               r_res_count_err;

    logic [COORD_W-1:0] w_res_x;
    logic [COORD_W-1:0] w_res_y;
    logic               w_res_full;
    logic               w_res_window;
    logic               w_res_wr;
    logic               w_res_drop;
    logic               w_res_clear;

    // Medians are only meaningful while the engine owns the frame.
    assign w_res_window = (r_state == FILTER) || (r_state == FLUSH);
    assign w_res_wr     = engMedianValid && w_res_window && !w_res_full;
    assign w_res_drop   = engMedianValid && w_res_window &&  w_res_full;
    assign w_res_clear  = (r_state == IDLE) && start;

    median_res_addr_gen #(
        .OUT_W (OUT_W),
        .OUT_H (OUT_H)
    ) u_res_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_res_clear),
        .i_advance (w_res_wr),
        .o_res_x   (w_res_x),
        .o_res_y   (w_res_y),
        .o_full    (w_res_full)
    );

    // Frame FSM; host-visible status outputs are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_flush_cnt     <= '0;
            r_host_ready    <= 1'b0;
            r_eng_start     <= 1'b0;
            r_busy          <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_count   <= '0;
            r_host_overrun  <= 1'b0;
            r_res_count_err <= 1'b0;
        end else begin
            // Sticky error capture; the IDLE start branch below overrides with a clear.
            if (hostWrEn && (r_state != LOAD)) r_host_overrun <= 1'b1;
            if (w_res_drop)                    r_res_count_err <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state         <= LOAD;
                        r_host_ready    <= 1'b1;
                        r_busy          <= 1'b1;
                        r_host_overrun  <= 1'b0;
                        r_res_count_err <= 1'b0;
                    end
                end
                LOAD: begin
                    if (hostLoadDone) begin
                        r_state      <= ARM;
                        r_host_ready <= 1'b0;
                        r_eng_start  <= 1'b1;
                    end
                end
                ARM: begin
                    r_state     <= FILTER;
                    r_eng_start <= 1'b0;
                end
                FILTER: begin
                    if (engFullImageDone) begin
                        r_state     <= FLUSH;
                        r_flush_cnt <= FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (r_flush_cnt == '0) begin
                        r_state       <= DONE;
                        r_frame_done  <= 1'b1;
                        r_frame_count <= r_frame_count + 1'b1;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_state      <= IDLE;
                    r_frame_done <= 1'b0;
                    r_busy       <= 1'b0;
                    // A full region is the only way to have written exactly OUT_W*OUT_H.
                    if (!w_res_full) r_res_count_err <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Source/result RAM port muxing driven straight from the current phase.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        memAddr   = '0;
        memWrEn   = 1'b0;
        memWrData = 1'b0;
        resAddr   = '0;
        resWrEn   = 1'b0;
        resWrData = 1'b0;
        case (r_state)
            LOAD: begin
                memAddr   = pack_addr(hostY, hostX);
                memWrEn   = hostWrEn;
                memWrData = hostData;
            end
            FILTER, FLUSH: memAddr = pack_addr(engY, engX);
            default: ;
        endcase
        if (w_res_wr) begin
            resWrEn   = 1'b1;
            resAddr   = pack_addr(w_res_y, w_res_x);
            resWrData = engMedianData;
        end
    end

    // RAM read latency is absorbed by the engine, so data passes straight through.
    assign engDataIn   = memRdData;
    assign hostReady   = r_host_ready;
    assign engStart    = r_eng_start;
    assign busy        = r_busy;
    assign frameDone   = r_frame_done;
    assign frameCount  = r_frame_count;
    assign hostOverrun = r_host_overrun;
    assign resCountErr = r_res_count_err;

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Directed-plus-random bench for median_frame_ctrl on an 8x8 image.
module tb_median_frame_ctrl;

    localparam int IMG_W     = 8;
    localparam int IMG_H     = 8;
    localparam int FLUSH_CYC = 4;
    localparam int OUT_W     = IMG_W - 2;
    localparam int OUT_H     = IMG_H - 2;
    localparam int N_RES     = OUT_W * OUT_H;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        hostReady;
    logic        hostWrEn;
    logic [7:0]  hostX;
    logic [7:0]  hostY;
    logic        hostData;
    logic        hostLoadDone;
    logic        engStart;
    logic [7:0]  engX;
    logic [7:0]  engY;
    logic        engDataIn;
    logic        engFullImageDone;
    logic        engMedianValid;
    logic        engMedianData;
    logic [15:0] memAddr;
    logic        memWrEn;
    logic        memWrData;
    logic        memRdData;
    logic [15:0] resAddr;
    logic        resWrEn;
    logic        resWrData;
    logic        busy;
    logic        frameDone;
    logic [7:0]  frameCount;
    logic        hostOverrun;
    logic        resCountErr;

    int errors = 0;
    int checks = 0;

    // Reference state: source image contents, results accepted this frame,
    // whether the region overflowed, and frames completed since reset.
    bit src_img [IMG_H][IMG_W];
    int res_written;
    bit res_overflow;
    int frames_done;

    median_frame_ctrl #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .FLUSH_CYC (FLUSH_CYC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .hostReady        (hostReady),
        .hostWrEn         (hostWrEn),
        .hostX            (hostX),
        .hostY            (hostY),
        .hostData         (hostData),
        .hostLoadDone     (hostLoadDone),
        .engStart         (engStart),
        .engX             (engX),
        .engY             (engY),
        .engDataIn        (engDataIn),
        .engFullImageDone (engFullImageDone),
        .engMedianValid   (engMedianValid),
        .engMedianData    (engMedianData),
        .memAddr          (memAddr),
        .memWrEn          (memWrEn),
        .memWrData        (memWrData),
        .memRdData        (memRdData),
        .resAddr          (resAddr),
        .resWrEn          (resWrEn),
        .resWrData        (resWrData),
        .busy             (busy),
        .frameDone        (frameDone),
        .frameCount       (frameCount),
        .hostOverrun      (hostOverrun),
        .resCountErr      (resCountErr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Start a frame, optionally loading a fresh random image, and walk through ARM.
    task automatic start_frame(input bit do_load);
        int wr_pulses;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_in_load", busy, 1);
        check("host_ready_in_load", hostReady, 1);
        check("overrun_cleared_by_start", hostOverrun, 0);
        check("count_err_cleared_by_start", resCountErr, 0);
        res_written  = 0;
        res_overflow = 0;
        wr_pulses    = 0;
        if (do_load) begin
            for (int y = 0; y < IMG_H; y++) begin
                for (int x = 0; x < IMG_W; x++) begin
                    hostWrEn     = 1'b1;
                    hostX        = 8'(x);
                    hostY        = 8'(y);
                    hostData     = 1'($urandom_range(0, 1));
                    src_img[y][x] = hostData;
                    hostLoadDone = (y == IMG_H - 1) && (x == IMG_W - 1);
                    #1;
                    if (memWrEn === 1'b1) wr_pulses++;
                    check("load_addr", memAddr, y * 256 + x);
                    check("load_data", memWrData, src_img[y][x]);
                    tick();
                end
            end
            check("load_write_pulses", wr_pulses, IMG_W * IMG_H);
        end else begin
            hostLoadDone = 1'b1;
            tick();
        end
        hostWrEn     = 1'b0;
        hostLoadDone = 1'b0;
        engX         = 8'd4;
        engY         = 8'd2;
        #1;
        check("eng_start_in_arm", engStart, 1);
        check("host_ready_off_in_arm", hostReady, 0);
        check("mem_addr_zero_in_arm", memAddr, 0);
        tick();
        check("eng_start_single_cycle", engStart, 0);
    endtask

    // One engine median strobe, compared with the raster-order model.
    task automatic emit_valid();
        logic d;
        d              = 1'($urandom_range(0, 1));
        engMedianValid = 1'b1;
        engMedianData  = d;
        #1;
        if (res_written < N_RES) begin
            check("res_wr_en", resWrEn, 1);
            check("res_addr", resAddr, (res_written / OUT_W) * 256 + (res_written % OUT_W));
            check("res_data", resWrData, d);
            res_written++;
        end else begin
            check("res_suppressed", resWrEn, 0);
            res_overflow = 1'b1;
        end
        tick();
        engMedianValid = 1'b0;
        repeat ($urandom_range(0, 1)) tick();
    endtask

    // Emit medians, end the scan, optionally send one in FLUSH, then await DONE.
    task automatic filter_and_finish(input int n_filter, input bit late_valid);
        int since_done;
        int done_pulses;
        int done_at;
        for (int i = 0; i < n_filter; i++) emit_valid();
        engFullImageDone = 1'b1;
        tick();
        engFullImageDone = 1'b0;
        since_done = 0;
        if (late_valid) begin
            tick();
            tick();
            since_done = 2;
            // Single late strobe three cycles after the scan ended.
            engMedianValid = 1'b1;
            engMedianData  = 1'b1;
            #1;
            check("flush_res_wr_en", resWrEn, 1);
            check("flush_res_addr", resAddr, (res_written / OUT_W) * 256 + (res_written % OUT_W));
            res_written++;
            tick();
            engMedianValid = 1'b0;
            since_done = 3;
        end
        done_pulses = 0;
        done_at     = -1;
        repeat (12) begin
            tick();
            since_done++;
            if (frameDone === 1'b1) begin
                done_pulses++;
                if (done_at < 0) done_at = since_done;
            end
        end
        frames_done++;
        check("frame_done_pulses", done_pulses, 1);
        check("frame_done_delay", done_at, FLUSH_CYC);
        check("frame_count", frameCount, frames_done % 256);
        check("busy_after_frame", busy, 0);
        check("res_count_err", resCountErr, (res_written != N_RES) || res_overflow);
    endtask

    initial begin
        reset            = 1'b1;
        start            = 1'b0;
        hostWrEn         = 1'b0;
        hostX            = '0;
        hostY            = '0;
        hostData         = 1'b0;
        hostLoadDone     = 1'b0;
        engX             = '0;
        engY             = '0;
        engFullImageDone = 1'b0;
        engMedianValid   = 1'b0;
        engMedianData    = 1'b0;
        memRdData        = 1'b0;
        frames_done      = 0;
        repeat (3) tick();

        check("reset_busy", busy, 0);
        check("reset_host_ready", hostReady, 0);
        check("reset_eng_start", engStart, 0);
        check("reset_frame_count", frameCount, 0);
        check("reset_mem_addr", memAddr, 0);
        check("reset_res_wr_en", resWrEn, 0);
        check("reset_flags", {hostOverrun, resCountErr, frameDone}, 0);
        reset = 1'b0;
        tick();

        // Frame 1: full load, read path, host overrun, 35 medians + 1 in FLUSH.
        start_frame(1'b1);
        hostWrEn = 1'b1;
        hostX    = 8'd1;
        hostY    = 8'd1;
        #1;
        check("filter_host_write_dropped", memWrEn, 0);
        tick();
        hostWrEn = 1'b0;
        check("host_overrun_set", hostOverrun, 1);
        for (int i = 0; i < 4; i++) begin
            engX      = 8'($urandom_range(0, IMG_W - 1));
            engY      = 8'($urandom_range(0, IMG_H - 1));
            memRdData = src_img[engY][engX];
            #1;
            check("filter_mem_addr", memAddr, engY * 256 + engX);
            check("filter_mem_wr_en", memWrEn, 0);
            check("eng_data_in", engDataIn, src_img[engY][engX]);
            tick();
        end
        memRdData = 1'b0;
        filter_and_finish(N_RES - 1, 1'b1);

        // Frame 2: one median too many; the extra one must be dropped.
        start_frame(1'b0);
        filter_and_finish(N_RES + 1, 1'b0);

        // Frame 3: one median short.
        start_frame(1'b0);
        filter_and_finish(N_RES - 1, 1'b0);

        // A strobe while idle never reaches the result RAM.
        engMedianValid = 1'b1;
        #1;
        check("idle_valid_ignored", resWrEn, 0);
        tick();
        engMedianValid = 1'b0;

        // Frame 4: reset asserted mid-FILTER clears everything without a clock edge.
        start_frame(1'b0);
        repeat (3) emit_valid();
        engX           = 8'd5;
        engY           = 8'd3;
        engMedianValid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_frame_count", frameCount, 0);
        check("abort_mem_addr", memAddr, 0);
        check("abort_res_wr_en", resWrEn, 0);
        check("abort_outputs", {hostReady, engStart, frameDone, hostOverrun, resCountErr, memWrEn}, 0);
        tick();
        engMedianValid = 1'b0;
        reset          = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
